// File: rtl/lc3_mem_pkg.sv
// Shared types and default constants for the LC3 bench memory responder.
package lc3_mem_pkg;

  // Per-channel handshake state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  // Default parameter values used by the top level.
  localparam logic [15:0] BASE_ADDR    = 16'h3000;
  localparam int          STALL_THRESH = 1000;
  localparam int          WAIT_W       = 4;

endpackage

// File: rtl/lc3_mem_chan_fsm.sv
// One request/complete channel: accepts a held request, counts out the
// programmed wait states, pulses complete for one cycle, aborts on a dropped
// request. The datapath that goes with the channel lives in the top.
module lc3_mem_chan_fsm
  #(parameter int WAIT_W = 4)
  (input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic [WAIT_W-1:0] wait_val,
   output logic              accept,      // this edge captures a new request
   output logic              enter_done,  // this edge moves into DONE
   output logic              complete);   // registered DONE indication

  import lc3_mem_pkg::*;

  ch_state_e         state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // State and wait-counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: acceptance from IDLE/DONE, countdown in WAIT, abort on drop.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (req) begin
          accept = 1'b1;
          if (wait_val == '0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_val;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_W'(1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_d == DONE);
  assign complete   = (state_q == DONE);

endmodule

// File: rtl/lc3_mem_responder.sv
// Cycle-accurate memory slave for the LC3 instruction and data ports: shared
// backing store, per-channel programmable wait states, fetch-stall watchdog.
module lc3_mem_responder
  #(parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 16,
    parameter int                DEPTH_LOG2   = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(lc3_mem_pkg::BASE_ADDR),
    parameter int                WAIT_W       = lc3_mem_pkg::WAIT_W,
    parameter int                STALL_THRESH = lc3_mem_pkg::STALL_THRESH)
  (input  logic              clock,
   input  logic              reset,
   input  logic              instrmem_rd,
   input  logic [ADDR_W-1:0] pc,
   input  logic [WAIT_W-1:0] instr_wait,
   output logic [DATA_W-1:0] Instr_dout,
   output logic              complete_instr,
   input  logic              data_en,
   input  logic              Data_rd,
   input  logic [ADDR_W-1:0] Data_addr,
   input  logic [DATA_W-1:0] Data_din,
   input  logic [WAIT_W-1:0] data_wait,
   output logic [DATA_W-1:0] Data_dout,
   output logic              complete_data,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              stall_err);

  import lc3_mem_pkg::*;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WD_W  = $clog2(STALL_THRESH + 1);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  // Offset from BASE_ADDR in address width, truncated; low addresses wrap.
  function automatic idx_t to_idx(input logic [ADDR_W-1:0] addr);
    return idx_t'(addr - BASE_ADDR);
  endfunction

  logic [DATA_W-1:0] store [DEPTH];

  logic i_accept, i_enter_done;
  logic d_accept, d_enter_done;

  idx_t              i_idx_q, d_idx_q;
  logic              d_rd_q;
  logic [DATA_W-1:0] d_din_q;

  idx_t              i_idx_sel, d_idx_sel;
  logic              d_rd_sel;
  logic [DATA_W-1:0] d_din_sel;

  logic [WD_W-1:0]   wd_cnt;

  lc3_mem_chan_fsm #(.WAIT_W(WAIT_W)) u_instr_fsm (
    .clock      (clock),
    .reset      (reset),
    .req        (instrmem_rd),
    .wait_val   (instr_wait),
    .accept     (i_accept),
    .enter_done (i_enter_done),
    .complete   (complete_instr)
  );

  lc3_mem_chan_fsm #(.WAIT_W(WAIT_W)) u_data_fsm (
    .clock      (clock),
    .reset      (reset),
    .req        (data_en),
    .wait_val   (data_wait),
    .accept     (d_accept),
    .enter_done (d_enter_done),
    .complete   (complete_data)
  );

  // A zero-wait request enters DONE on its own acceptance edge, so the live
  // inputs are used then; otherwise the values captured at acceptance.
  assign i_idx_sel = i_accept ? to_idx(pc)        : i_idx_q;
  assign d_idx_sel = d_accept ? to_idx(Data_addr) : d_idx_q;
  assign d_rd_sel  = d_accept ? Data_rd           : d_rd_q;
  assign d_din_sel = d_accept ? Data_din          : d_din_q;

  // Request capture at acceptance; contents are don't-care until first use.
  always_ff @(posedge clock) begin
    if (i_accept) i_idx_q <= to_idx(pc);
    if (d_accept) begin
      d_idx_q <= to_idx(Data_addr);
      d_rd_q  <= Data_rd;
      d_din_q <= Data_din;
    end
  end

  // Backing store writes: preload first, data write last so it wins a tie.
  // NOTE: the store is deliberately not reset -- committed contents must
  // survive reset, and a reset on an array blocks RAM inference.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (load_en) store[to_idx(load_addr)] <= load_data;
      if (d_enter_done && !d_rd_sel) store[d_idx_sel] <= d_din_sel;
    end
  end

  // Read data registered on entry to DONE; reads see pre-edge contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Instr_dout <= '0;
      Data_dout  <= '0;
    end else begin
      if (i_enter_done) Instr_dout <= store[i_idx_sel];
      if (d_enter_done) Data_dout  <= d_rd_sel ? store[d_idx_sel] : '0;
    end
  end

  // Fetch-stall watchdog: saturating count of cycles without complete_instr.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else if (complete_instr) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(STALL_THRESH)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt == WD_W'(STALL_THRESH - 1)) stall_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: directed scenarios plus a
// randomized transaction mix against an array model of the store.
module tb_lc3_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic [3:0]  instr_wait;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        data_en;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [3:0]  data_wait;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        stall_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem   [4096];
  bit          model_valid [4096];

  lc3_mem_responder dut (
    .clock          (clock),
    .reset          (reset),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .instr_wait     (instr_wait),
    .Instr_dout     (Instr_dout),
    .complete_instr (complete_instr),
    .data_en        (data_en),
    .Data_rd        (Data_rd),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .data_wait      (data_wait),
    .Data_dout      (Data_dout),
    .complete_data  (complete_data),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .stall_err      (stall_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Store index of an address: offset from 0x3000 modulo the 4096-word store.
  function automatic int ix(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h3000;
    return int'(off) % 4096;
  endfunction

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
    model_mem[ix(a)]   = d;
    model_valid[ix(a)] = 1'b1;
  endtask

  task automatic data_txn(input bit rd, input logic [15:0] a, input logic [15:0] d,
                          input logic [3:0] w, input string tag);
    int lat;
    @(negedge clock);
    data_en = 1'b1; Data_rd = rd; Data_addr = a; Data_din = d; data_wait = w;
    lat = 0;
    do begin
      @(posedge clock); #1; lat++;
    end while (!complete_data && lat < 40);
    data_en = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(int'(w) + 1));
    if (rd) begin
      if (model_valid[ix(a)]) check({tag, " rdata"}, 32'(Data_dout), 32'(model_mem[ix(a)]));
    end else begin
      check({tag, " wr dout"}, 32'(Data_dout), 32'h0);
      model_mem[ix(a)]   = d;
      model_valid[ix(a)] = 1'b1;
    end
    @(posedge clock); #1;
    check({tag, " pulse end"}, 32'(complete_data), 32'h0);
  endtask

  task automatic instr_txn(input logic [15:0] a, input logic [3:0] w, input string tag);
    int lat;
    @(negedge clock);
    instrmem_rd = 1'b1; pc = a; instr_wait = w;
    lat = 0;
    do begin
      @(posedge clock); #1; lat++;
    end while (!complete_instr && lat < 40);
    instrmem_rd = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(int'(w) + 1));
    if (model_valid[ix(a)]) check({tag, " idata"}, 32'(Instr_dout), 32'(model_mem[ix(a)]));
    @(posedge clock); #1;
    check({tag, " pulse end"}, 32'(complete_instr), 32'h0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    instrmem_rd = 1'b0; pc = '0; instr_wait = '0;
    data_en = 1'b0; Data_rd = 1'b0; Data_addr = '0; Data_din = '0; data_wait = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clock);
    check("rst Instr_dout",     32'(Instr_dout),     32'h0);
    check("rst Data_dout",      32'(Data_dout),      32'h0);
    check("rst complete_instr", 32'(complete_instr), 32'h0);
    check("rst complete_data",  32'(complete_data),  32'h0);
    check("rst stall_err",      32'(stall_err),      32'h0);
    reset = 1'b0;

    load(16'h3000, 16'h1234);
    load(16'h3001, 16'h5678);
    load(16'h3010, 16'h0001);
    load(16'h3020, 16'h7777);
    load(16'h3021, 16'h2222);

    // Held zero-wait fetch: completes every cycle, pc resampled each edge.
    @(negedge clock);
    instrmem_rd = 1'b1; pc = 16'h3000; instr_wait = 4'd0;
    @(posedge clock); #1;
    check("burst c0", 32'(complete_instr), 32'h1);
    check("burst d0", 32'(Instr_dout), 32'h1234);
    pc = 16'h3001;
    @(posedge clock); #1;
    check("burst c1", 32'(complete_instr), 32'h1);
    check("burst d1", 32'(Instr_dout), 32'h5678);
    instrmem_rd = 1'b0;
    @(posedge clock); #1;
    check("burst end", 32'(complete_instr), 32'h0);

    instr_txn(16'h3000, 4'd3, "fetch w3");

    data_txn(1'b0, 16'h3005, 16'hBEEF, 4'd2, "dwrite w2");
    data_txn(1'b1, 16'h3005, 16'h0000, 4'd2, "dread w2");

    // Data write and instruction fetch of the same word on one edge.
    @(negedge clock);
    instrmem_rd = 1'b1; pc = 16'h3010; instr_wait = 4'd0;
    data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3010; Data_din = 16'hAAAA; data_wait = 4'd0;
    @(posedge clock); #1;
    check("coll ci", 32'(complete_instr), 32'h1);
    check("coll cd", 32'(complete_data), 32'h1);
    check("coll old word", 32'(Instr_dout), 32'h0001);
    instrmem_rd = 1'b0; data_en = 1'b0;
    model_mem[ix(16'h3010)] = 16'hAAAA;
    @(posedge clock);
    instr_txn(16'h3010, 4'd0, "coll refetch");

    // Write abandoned in WAIT: no completion, store unchanged.
    @(negedge clock);
    data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3020; Data_din = 16'hDEAD; data_wait = 4'd5;
    repeat (2) @(posedge clock);
    #1;
    data_en = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      if (complete_data) seen = 1'b1;
    end
    check("abort no complete", 32'(seen), 32'h0);
    data_txn(1'b1, 16'h3020, 16'h0000, 4'd0, "abort readback");

    // Reset in the middle of pending operations.
    @(negedge clock);
    data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3021; Data_din = 16'h1111; data_wait = 4'd5;
    instrmem_rd = 1'b1; pc = 16'h3000; instr_wait = 4'd7;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midrst Instr_dout",     32'(Instr_dout),     32'h0);
    check("midrst Data_dout",      32'(Data_dout),      32'h0);
    check("midrst complete_instr", 32'(complete_instr), 32'h0);
    check("midrst complete_data",  32'(complete_data),  32'h0);
    data_en = 1'b0; instrmem_rd = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    data_txn(1'b1, 16'h3021, 16'h0000, 4'd1, "midrst keep");
    instr_txn(16'h3000, 4'd0, "midrst fetch");

    // Randomized mix, including addresses that wrap below the base.
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      logic [15:0] d;
      logic [3:0]  w;
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h3000 + 16'($urandom_range(0, 31));
      d = 16'($urandom);
      w = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       load(a, d);
        1:       data_txn(1'b0, a, d, w, "rnd write");
        2:       data_txn(1'b1, a, d, w, "rnd read");
        default: instr_txn(a, w, "rnd fetch");
      endcase
    end

    // Watchdog: sets on the STALL_THRESH-th idle cycle, sticky until reset.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (999) @(posedge clock);
    #1;
    check("wd before thresh", 32'(stall_err), 32'h0);
    @(posedge clock); #1;
    check("wd at thresh", 32'(stall_err), 32'h1);
    instr_txn(16'h3001, 4'd0, "wd fetch");
    check("wd sticky", 32'(stall_err), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("wd reset clears", 32'(stall_err), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Parametrised, cycle-accurate memory slave that serves the LC3 instruction-fetch and data-access ports of the verification bench.
- Replaces the zero-wait, always-complete memory behaviour with independently programmable wait states per channel, a shared backing store and a fetch-stall watchdog.
- Sits beside the DUT in the bench top.
- Drives Instr_dout/complete_instr and Data_dout/complete_data.

Parameters:
- ADDR_W, 16, address width of both channels.
- DATA_W, 16, word width.
- DEPTH_LOG2, 12, log2 of backing-store word count.
- BASE_ADDR, 16'h3000, address that maps to store index 0.
- WAIT_W, 4, width of the wait-state inputs.
- STALL_THRESH, 1000, cycles without complete_instr before stall_err is set.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instrmem_rd  in  1  instruction read request, held until completion.
- pc  in  ADDR_W  instruction address.
- instr_wait  in  WAIT_W  instruction wait states, sampled at request acceptance.
- Instr_dout  out  DATA_W  instruction word, valid while complete_instr = 1.
- complete_instr  out  1  instruction completion pulse.
- data_en  in  1  data request strobe, held until completion.
- Data_rd  in  1  1 = read, 0 = write.
- Data_addr  in  ADDR_W  data address.
- Data_din  in  DATA_W  write data.
- data_wait  in  WAIT_W  data wait states, sampled at acceptance.
- Data_dout  out  DATA_W  read data, valid while complete_data = 1.
- complete_data  out  1  data completion pulse.
- load_en  in  1  bench preload write enable.
- load_addr  in  ADDR_W  preload address.
- load_data  in  DATA_W  preload data.
- stall_err  out  1  sticky watchdog flag.

Behaviour:
- Address mapping:
  - index = (addr − BASE_ADDR) mod 2^DEPTH_LOG2, computed in ADDR_W bits and truncated.
  - Addresses below BASE_ADDR wrap; no error is raised.
- Reset:
  - Instr_dout, Data_dout, complete_instr, complete_data, stall_err = 0.
  - Both channel FSMs go to IDLE; the watchdog counter goes to 0.
  - Store contents are NOT cleared.
- Each channel has its own FSM with states IDLE, WAIT, DONE, and its own counter of width WAIT_W.
- Acceptance (in IDLE or DONE, with the request high at the edge):
  - Capture address, Data_rd, Data_din and the wait value w.
  - w = 0 → DONE next cycle; w > 0 → WAIT with cnt = w.
- WAIT:
  - cnt decrements each cycle; at cnt = 1 → DONE.
  - Latency from the acceptance edge to the complete pulse = w+1 cycles.
- Request dropped while in WAIT: abort to IDLE, no completion, no write.
- DONE:
  - complete_* = 1 for exactly this cycle.
  - Read data is registered on entry: store[captured index].
  - A write commits to the store on the edge entering DONE; Data_dout is then 0.
  - If the request is still high, this edge accepts a new request. A held request with w = 0 therefore completes every cycle, with the address resampled every cycle.
  - If the request is low → IDLE.
- Same-edge collisions:
  - Instruction read and data write to the same index on the same edge: instruction returns the old word (read-first).
  - Data read and data write on the same edge are not possible (single data channel).
  - load_en and a committing data write to the same index: data write wins.
  - load_en against reads: read-first.
- load_en writes the store on any cycle, independent of both FSMs; it is ignored during reset.
- Watchdog:
  - Counter clears on complete_instr = 1 and otherwise increments, saturating at STALL_THRESH.
  - When it reaches STALL_THRESH, stall_err = 1, sticky until reset.
- Reset mid-operation aborts any pending write; the store keeps all committed data.

Decomposition:
- Shared package lc3_mem_pkg:
  - ch_state_e enum {IDLE, WAIT, DONE}.
  - Default constants BASE_ADDR, STALL_THRESH, WAIT_W.
- Sub-module lc3_mem_chan_fsm (acceptance, wait counter, complete pulse, abort) is instantiated twice.
- Store and watchdog stay in the top.

Test Plan:
- Reset, then preload 0x3000=0x1234 and 0x3001=0x5678. Hold instrmem_rd with pc 0x3000 then 0x3001, instr_wait=0 → complete_instr every cycle, Instr_dout 0x1234 then 0x5678.
- instr_wait=3, pc=0x3000 → complete_instr pulses 4 cycles after acceptance, high for one cycle.
- Data write 0x3005←0xBEEF with data_wait=2, then a read of 0x3005 → complete_data after 3 cycles each; read returns 0xBEEF.
- Data write 0xAAAA to 0x3010 committing on the same edge as an instruction fetch of 0x3010 holding 0x0001 → Instr_dout = 0x0001; a following fetch returns 0xAAAA.
- Drop data_en during WAIT (data_wait=5) on a write of 0x3020 → no complete_data; 0x3020 unchanged. Separately, assert reset mid-WAIT → all outputs 0; preloaded contents still readable.
- Hold instrmem_rd low for STALL_THRESH cycles → stall_err rises at cycle 1000 and stays high after fetches resume; cleared only by reset.
